// File: rtl/demux_pkg.sv
// Shared constants and types for the 16-bit 1-to-8 registered demultiplexer.
package demux_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned LANES = 8;
    localparam int unsigned SEL_W = $clog2(LANES);

    typedef enum logic {
        IDLE,
        BCAST
    } demux_state_t;

    typedef logic [WIDTH-1:0] word_t;

endpackage : demux_pkg

// File: rtl/demux_lane.sv
// One output holding lane: data register, valid flag and a "free this cycle" indication.
module demux_lane
    import demux_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  wr_en_i,
    input  word_t wr_data_i,
    input  logic  ack_i,
    output word_t q_o,
    output logic  valid_o,
    output logic  free_c_o
);

    word_t data_q;
    logic  valid_q;

    // A write in the same cycle as an ack wins; data is kept after an ack.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (wr_en_i) begin
            data_q  <= wr_data_i;
            valid_q <= 1'b1;
        end else if (ack_i) begin
            valid_q <= 1'b0;
        end
    end

    assign q_o      = data_q;
    assign valid_o  = valid_q;
    assign free_c_o = !valid_q || ack_i;

endmodule : demux_lane

// File: rtl/demux_16w_1_to_8.sv
// Registered 1-to-8 demux for 16-bit words with per-lane ack and a sequenced
// broadcast that walks lanes 0..7, stalling on any lane that is still occupied.
module demux_16w_1_to_8
    import demux_pkg::*;
(
    input  logic                   Clk,
    input  logic                   ResetN,
    input  logic [WIDTH-1:0]       D,
    input  logic [SEL_W-1:0]       Sel,
    input  logic                   Bcast,
    input  logic                   InValid,
    output logic                   InReady,
    output logic [LANES*WIDTH-1:0] Q,
    output logic [LANES-1:0]       QValid,
    input  logic [LANES-1:0]       QAck,
    output logic                   Busy
);

    demux_state_t     state_q;
    logic [SEL_W-1:0] ptr_q;
    word_t            bcast_data_q;
    logic             busy_q;

    logic [LANES-1:0] lane_free;
    logic [LANES-1:0] lane_wr_en;
    word_t            lane_wr_data;
    word_t            lane_q [LANES];
    logic             xfer;

    // Ready is combinational so a single write can land on a lane being acked this cycle.
    always_comb begin
        InReady = 1'b0;
        if (ResetN && (state_q == IDLE)) begin
            InReady = Bcast || lane_free[Sel];
        end
    end

    assign xfer = InValid && InReady;

    // Write-enable decode: single write from the input, or the broadcast pointer lane.
    always_comb begin
        lane_wr_en   = '0;
        lane_wr_data = D;
        if (state_q == BCAST) begin
            lane_wr_data      = bcast_data_q;
            lane_wr_en[ptr_q] = lane_free[ptr_q];
        end else if (xfer && !Bcast) begin
            lane_wr_en[Sel] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            bcast_data_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer && Bcast) begin
                        bcast_data_q <= D;
                        ptr_q        <= '0;
                        state_q      <= BCAST;
                        busy_q       <= 1'b1;
                    end
                end
                BCAST: begin
                    // ptr wraps to 0 exactly when the last lane is written.
                    if (lane_free[ptr_q]) begin
                        ptr_q <= ptr_q + SEL_W'(1);
                        if (ptr_q == SEL_W'(LANES - 1)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        demux_lane u_lane (
            .clk_i     (Clk),
            .rst_ni    (ResetN),
            .wr_en_i   (lane_wr_en[i]),
            .wr_data_i (lane_wr_data),
            .ack_i     (QAck[i]),
            .q_o       (lane_q[i]),
            .valid_o   (QValid[i]),
            .free_c_o  (lane_free[i])
        );
        assign Q[i*WIDTH +: WIDTH] = lane_q[i];
    end

endmodule : demux_16w_1_to_8
